// File: rtl/conv_vwin.sv
// Purpose: vertical window former; emits one KERNEL_DIAMETER_N-tall pixel column per accepted input pixel.
// Latency: one cycle from accepted input beat to registered output column.
// Backpressure: single output register; s_tready_o = m_tready_i || !m_tvalid_o, output held while stalled.
//
// Ports:
//   clk_i, rst_n                         clock, async active-low reset
//   s_tvalid_i/s_tdata_i/s_tlast_i/s_tuser_i/s_tready_o   pixel stream in (tlast = EOL, tuser = SOF)
//   m_tvalid_i/m_tdata_o/m_tlast_o/m_tuser_o/m_tready_i   column stream out, m_tdata_o slice k = k lines above
//   err_o                                sticky protocol error (line overflow or SOF mid-line)
module conv_vwin #(
  parameter int    PIXEL_W           = 8,
  parameter int    KERNEL_DIAMETER_N = 5,
  parameter int    MAX_WIDTH_N       = 1024,
  parameter string EXTEND_STRATEGY   = "ZERO_PAD",
  parameter string TARGET            = "FPGA"
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n,
  input  logic                                 s_tvalid_i,
  input  logic [PIXEL_W-1:0]                   s_tdata_i,
  input  logic                                 s_tlast_i,
  input  logic                                 s_tuser_i,
  output logic                                 s_tready_o,
  input  logic                                 m_tready_i,
  output logic                                 m_tvalid_o,
  output logic [KERNEL_DIAMETER_N*PIXEL_W-1:0] m_tdata_o,
  output logic                                 m_tuser_o,
  output logic                                 m_tlast_o,
  output logic                                 err_o
);

  localparam int AW = $clog2(MAX_WIDTH_N);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(KERNEL_DIAMETER_N);
  localparam int NB = KERNEL_DIAMETER_N - 1;
  localparam bit REPLICATE = (EXTEND_STRATEGY == "REPLICATE");
  localparam logic [RW-1:0] ROW_MAX = RW'(KERNEL_DIAMETER_N - 1);
  localparam logic [CW-1:0] COL_END = CW'(MAX_WIDTH_N);

  logic [CW-1:0] col;
  logic [RW-1:0] row_cnt;

  logic                                 acc;
  logic [CW-1:0]                        col_eff;
  logic [RW-1:0]                        row_eff;
  logic                                 ovf;
  logic                                 wr_en;
  logic [AW-1:0]                        addr;
  logic [PIXEL_W-1:0]                   rd [NB];
  logic [PIXEL_W-1:0]                   top;
  logic [KERNEL_DIAMETER_N*PIXEL_W-1:0] win_flat;

  assign s_tready_o = m_tready_i || !m_tvalid_o;
  assign acc        = s_tvalid_i && s_tready_o;
  // An SOF beat restarts the frame before the window is formed.
  assign col_eff    = s_tuser_i ? '0 : col;
  assign row_eff    = s_tuser_i ? '0 : row_cnt;
  // col only reaches MAX_WIDTH_N when a line ran past the buffers.
  assign ovf        = (col_eff == COL_END);
  assign addr       = col_eff[AW-1:0];
  assign wr_en      = acc && !ovf;

  // Line buffer k holds the line k+1 above the current one. Reads are
  // asynchronous so the window sees pre-update contents; writes shift each
  // column one buffer further up.
  for (genvar k = 0; k < NB; k++) begin : g_lb
    logic [PIXEL_W-1:0] wr_dat;
    if (k == 0) begin : g_head
      assign wr_dat = s_tdata_i;
    end else begin : g_tail
      assign wr_dat = rd[k-1];
    end
    if (TARGET == "ASIC") begin : g_mem
      logic [PIXEL_W-1:0] mem [MAX_WIDTH_N];
      always_ff @(posedge clk_i) begin
        if (wr_en) mem[addr] <= wr_dat;
      end
      assign rd[k] = mem[addr];
    end else begin : g_mem
      (* ram_style = "distributed" *) logic [PIXEL_W-1:0] mem [MAX_WIDTH_N];
      always_ff @(posedge clk_i) begin
        if (wr_en) mem[addr] <= wr_dat;
      end
      assign rd[k] = mem[addr];
    end
  end

  // Topmost line that belongs to the current frame; used for REPLICATE.
  always_comb begin
    top = s_tdata_i;
    for (int j = 0; j < NB; j++) begin
      if (int'(row_eff) == j + 1) top = rd[j];
    end
  end

  // Lines above the frame top hold stale data and are masked; an overflow
  // beat has no buffered history at all, so only the live pixel survives.
  always_comb begin
    win_flat = '0;
    win_flat[PIXEL_W-1:0] = s_tdata_i;
    for (int k = 1; k < KERNEL_DIAMETER_N; k++) begin
      if (ovf) begin
        win_flat[k*PIXEL_W +: PIXEL_W] = '0;
      end else if (k > int'(row_eff)) begin
        win_flat[k*PIXEL_W +: PIXEL_W] = REPLICATE ? top : '0;
      end else begin
        win_flat[k*PIXEL_W +: PIXEL_W] = rd[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tuser_o  <= 1'b0;
      m_tlast_o  <= 1'b0;
      err_o      <= 1'b0;
      col        <= '0;
      row_cnt    <= '0;
    end else if (acc) begin
      m_tvalid_o <= 1'b1;
      m_tdata_o  <= win_flat;
      m_tuser_o  <= s_tuser_i;
      m_tlast_o  <= s_tlast_i;
      if (s_tlast_i) begin
        col     <= '0;
        row_cnt <= (row_eff == ROW_MAX) ? row_eff : row_eff + 1'b1;
      end else begin
        // Saturate at MAX_WIDTH_N so every further beat stays flagged.
        col     <= ovf ? col_eff : col_eff + 1'b1;
        row_cnt <= row_eff;
      end
      if (s_tuser_i) begin
        err_o <= (col != '0);
      end else if (ovf) begin
        err_o <= 1'b1;
      end
    end else if (m_tready_i) begin
      m_tvalid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_vwin.sv
module tb_conv_vwin;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid_i = 1'b0;
  logic [7:0]  s_tdata_i = '0;
  logic        s_tlast_i = 1'b0;
  logic        s_tuser_i = 1'b0;
  logic        m_tready_i = 1'b1;

  logic        rdy_z, vld_z, usr_z, lst_z, err_z;
  logic        rdy_r, vld_r, usr_r, lst_r, err_r;
  logic [23:0] dat_z, dat_r;

  always #5 clk_i = ~clk_i;

  conv_vwin #(.PIXEL_W(8), .KERNEL_DIAMETER_N(3), .MAX_WIDTH_N(4),
              .EXTEND_STRATEGY("ZERO_PAD"), .TARGET("FPGA")) dut_z (
    .clk_i(clk_i), .rst_n(rst_n),
    .s_tvalid_i(s_tvalid_i), .s_tdata_i(s_tdata_i), .s_tlast_i(s_tlast_i),
    .s_tuser_i(s_tuser_i), .s_tready_o(rdy_z),
    .m_tready_i(m_tready_i), .m_tvalid_o(vld_z), .m_tdata_o(dat_z),
    .m_tuser_o(usr_z), .m_tlast_o(lst_z), .err_o(err_z));

  conv_vwin #(.PIXEL_W(8), .KERNEL_DIAMETER_N(3), .MAX_WIDTH_N(4),
              .EXTEND_STRATEGY("REPLICATE"), .TARGET("ASIC")) dut_r (
    .clk_i(clk_i), .rst_n(rst_n),
    .s_tvalid_i(s_tvalid_i), .s_tdata_i(s_tdata_i), .s_tlast_i(s_tlast_i),
    .s_tuser_i(s_tuser_i), .s_tready_o(rdy_r),
    .m_tready_i(m_tready_i), .m_tvalid_o(vld_r), .m_tdata_o(dat_r),
    .m_tuser_o(usr_r), .m_tlast_o(lst_r), .err_o(err_r));

  typedef struct {
    logic [23:0] z;
    logic [23:0] r;
    logic        u;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [23:0] col3(input logic [7:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: pops one expected column per output handshake.
  logic        prev_stall = 1'b0;
  logic [23:0] prev_dat   = '0;
  always @(negedge clk_i) begin
    if (rst_n) begin
      if (prev_stall && vld_z) check("stall_hold", {8'd0, dat_z}, {8'd0, prev_dat});
      if (vld_z && m_tready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_col", {8'd0, dat_z}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("col_zero_pad", {8'd0, dat_z}, {8'd0, e.z});
          check("col_replicate", {8'd0, dat_r}, {8'd0, e.r});
          check("tuser", {31'd0, usr_z}, {31'd0, e.u});
          check("tlast", {31'd0, lst_z}, {31'd0, e.l});
          check("vld_pair", {31'd0, vld_r}, 32'd1);
        end
      end
      prev_stall = vld_z && !m_tready_i;
      prev_dat   = dat_z;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [7:0] d, input logic u, input logic l,
                      input logic [23:0] ez, input logic [23:0] er);
    exp_t e;
    bit   done;
    e.z = ez; e.r = er; e.u = u; e.l = l;
    exp_q.push_back(e);
    s_tvalid_i = 1'b1; s_tdata_i = d; s_tuser_i = u; s_tlast_i = l;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_i);
      done = rdy_z;
      @(posedge clk_i);
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    #1;
    s_tvalid_i = 1'b0; s_tuser_i = 1'b0; s_tlast_i = 1'b0;
  endtask

  task automatic frame_basic();
    send(8'd1, 1'b1, 1'b0, col3(1, 0, 0), col3(1, 1, 1));
    send(8'd2, 1'b0, 1'b1, col3(2, 0, 0), col3(2, 2, 2));
    send(8'd3, 1'b0, 1'b0, col3(3, 1, 0), col3(3, 1, 1));
    send(8'd4, 1'b0, 1'b1, col3(4, 2, 0), col3(4, 2, 2));
    send(8'd5, 1'b0, 1'b0, col3(5, 3, 1), col3(5, 3, 1));
    send(8'd6, 1'b0, 1'b1, col3(6, 4, 2), col3(6, 4, 2));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"}, {30'd0, vld_z, vld_r}, 32'd0);
    check({tag, "_dat_z"}, {8'd0, dat_z}, 32'd0);
    check({tag, "_dat_r"}, {8'd0, dat_r}, 32'd0);
    check({tag, "_usr_lst"}, {28'd0, usr_z, usr_r, lst_z, lst_r}, 32'd0);
    check({tag, "_err"}, {30'd0, err_z, err_r}, 32'd0);
  endtask

  initial begin
    #12;
    check_reset_outputs("reset");
    @(posedge clk_i); #1;
    rst_n = 1'b1;

    // Basic frame, continuous ready.
    frame_basic();

    // Same frame with a 3-cycle downstream stall starting in line 2.
    fork
      frame_basic();
      begin
        repeat (3) @(posedge clk_i);
        #1 m_tready_i = 1'b0;
        @(negedge clk_i);
        check("stall_s_tready", {31'd0, rdy_z}, 32'd0);
        check("stall_m_tvalid", {31'd0, vld_z}, 32'd1);
        repeat (3) @(posedge clk_i);
        #1 m_tready_i = 1'b1;
      end
    join

    // Line overflow: 5 beats after SOF without tlast.
    send(8'd10, 1'b1, 1'b0, col3(10, 0, 0), col3(10, 10, 10));
    send(8'd11, 1'b0, 1'b0, col3(11, 0, 0), col3(11, 11, 11));
    send(8'd12, 1'b0, 1'b0, col3(12, 0, 0), col3(12, 12, 12));
    send(8'd13, 1'b0, 1'b0, col3(13, 0, 0), col3(13, 13, 13));
    check("err_before_ovf", {31'd0, err_z}, 32'd0);
    send(8'd14, 1'b0, 1'b0, col3(14, 0, 0), col3(14, 0, 0));
    check("err_ovf", {30'd0, err_z, err_r}, 32'd3);
    send(8'd15, 1'b0, 1'b1, col3(15, 0, 0), col3(15, 0, 0));
    check("err_sticky", {31'd0, err_z}, 32'd1);
    // SOF+tlast at col 0 clears err; single-pixel line then row 1.
    send(8'd20, 1'b1, 1'b1, col3(20, 0, 0), col3(20, 20, 20));
    check("err_clear", {30'd0, err_z, err_r}, 32'd0);
    send(8'd21, 1'b0, 1'b1, col3(21, 20, 0), col3(21, 20, 20));
    send(8'd30, 1'b0, 1'b0, col3(30, 21, 20), col3(30, 21, 20));
    // SOF arriving at col 1.
    send(8'd31, 1'b1, 1'b0, col3(31, 0, 0), col3(31, 31, 31));
    check("err_sof_midline", {30'd0, err_z, err_r}, 32'd3);
    send(8'd32, 1'b0, 1'b1, col3(32, 0, 0), col3(32, 32, 32));
    check("err_after_midline", {31'd0, err_z}, 32'd1);

    // Reset mid-frame during line 2, then the basic frame again.
    send(8'd40, 1'b1, 1'b0, col3(40, 0, 0), col3(40, 40, 40));
    send(8'd41, 1'b0, 1'b1, col3(41, 0, 0), col3(41, 41, 41));
    send(8'd42, 1'b0, 1'b0, col3(42, 40, 0), col3(42, 40, 40));
    repeat (2) @(posedge clk_i);
    check("queue_before_reset", exp_q.size(), 32'd0);
    #1 rst_n = 1'b0;
    #2;
    check_reset_outputs("midreset");
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    frame_basic();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_i);
    check("drain", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_vwin.md
CONV_VWIN -- requirements
Module: conv_vwin

Interface
REQ-001 Parameter PIXEL_W, default 8: pixel width in bits, 1..32.
REQ-002 Parameter KERNEL_DIAMETER_N, default 5: window height in lines, 2..9.
REQ-003 Parameter MAX_WIDTH_N, default 1024: maximum line length in pixels, power of two, 4..4096.
REQ-004 Parameter EXTEND_STRATEGY, default "ZERO_PAD": top-edge extension, "ZERO_PAD" | "REPLICATE".
REQ-005 Parameter TARGET, default "FPGA": line buffer implementation hint, "FPGA" | "ASIC"; no behavioural effect.
REQ-006 clk_i  input  1  sole clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 s_tvalid_i  input  1  input pixel valid.
REQ-009 s_tdata_i  input  PIXEL_W  input pixel.
REQ-010 s_tlast_i  input  1  last pixel of line.
REQ-011 s_tuser_i  input  1  first pixel of frame (SOF).
REQ-012 s_tready_o  output  1  input accept.
REQ-013 m_tready_i  input  1  downstream accept.
REQ-014 m_tvalid_o  output  1  window column valid.
REQ-015 m_tdata_o  output  KERNEL_DIAMETER_N x PIXEL_W  vertical column; index 0 = current line, index k = k lines above.
REQ-016 m_tuser_o, m_tlast_o  output  1 each  SOF/EOL, aligned with the column.
REQ-017 err_o  output  1  sticky protocol error flag.

Function
REQ-018 An input beat SHALL be accepted when s_tvalid_i && s_tready_o; s_tready_o = m_tready_i || !m_tvalid_o (single output register, full throughput, no combinational valid path).
REQ-019 Each accepted beat SHALL produce exactly one output column one cycle later; output held stable while m_tvalid_o && !m_tready_i.
REQ-020 State: col (log2 MAX_WIDTH_N + 1 bits), row_cnt (saturating 0..KERNEL_DIAMETER_N-1), KERNEL_DIAMETER_N-1 line buffers of MAX_WIDTH_N x PIXEL_W.
REQ-021 On an accepted beat at column c: output k>=1 SHALL read line buffer k-1 at c before update; then lb[0][c] <= s_tdata_i, lb[k][c] <= lb[k-1][c].
REQ-022 Effective row r = 0 on an SOF beat, else row_cnt.
REQ-023 For k > r: ZERO_PAD SHALL output 0; REPLICATE SHALL output the value index r would carry (topmost valid line).
REQ-024 Accepted SOF beat SHALL force col to 0 and row_cnt to 0 before the window is formed.
REQ-025 Accepted tlast beat SHALL set col to 0 and row_cnt to min(r+1, KERNEL_DIAMETER_N-1); otherwise col increments.
REQ-026 SOF and tlast on the same beat: row 0, single-pixel line, row_cnt becomes 1.
REQ-027 Overflow: beat accepted at col == MAX_WIDTH_N SHALL be emitted with index 0 = input, all other indices 0 regardless of strategy, no line buffer write, col saturates, err_o set.
REQ-028 SOF accepted with col != 0 SHALL set err_o and be handled per REQ-024.
REQ-029 err_o SHALL clear on an accepted SOF beat at col == 0, else remain set.
REQ-030 m_tuser_o/m_tlast_o SHALL register s_tuser_i/s_tlast_i of the same beat.

Reset
REQ-031 While rst_n is low: m_tvalid_o=0, m_tdata_o=0, m_tuser_o=0, m_tlast_o=0, err_o=0, col=0, row_cnt=0; line buffer contents not reset.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; output after release depends only on post-reset beats (REQ-023 masks stale buffers).

Verification (PIXEL_W=8, KERNEL_DIAMETER_N=3, MAX_WIDTH_N=4)
REQ-033 ZERO_PAD, 3 lines of width 2, pixels 1..6, continuous ready -> columns {1,0,0},{2,0,0},{3,1,0},{4,2,0},{5,3,1},{6,4,2}, tlast on 2nd/4th/6th, tuser on 1st only.
REQ-034 REPLICATE, same stimulus -> {1,1,1},{2,2,2},{3,1,1},{4,2,2},{5,3,1},{6,4,2}.
REQ-035 m_tready_i low 3 cycles during line 2 -> s_tready_o low after 1 buffered column, m_tdata_o stable, no beat lost or duplicated.
REQ-036 5 beats without tlast after SOF -> 5th column {x,0,0}, err_o=1; next SOF at col 0 -> err_o=0.
REQ-037 SOF mid-line at col 1 -> err_o=1, that beat emitted as row 0 column 0 with padded upper indices.
REQ-038 rst_n pulsed low during line 2 -> all outputs 0 during reset; next SOF frame reproduces REQ-033 output exactly.
